// File: rtl/lsu_param.sv
// Load/store unit: accepts one core access at a time, issues a single memory strobe,
// extracts and extends load data, and reports misalignment, illegal-size or timeout faults.
module lsu_param #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StResp} state_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e              state_q;
  logic                wen_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                fault_q;
  logic [15:0]         cnt_q;

  logic                req_bad;
  logic [3:0]          lane_mask;
  logic [31:0]         lane_wdata;
  logic [31:0]         rd_shift;
  logic [15:0]         rd_half;
  logic [31:0]         rd_ext;

  // Illegal size or misaligned address on the incoming request.
  always_comb begin
    req_bad = 1'b0;
    unique case (req_size)
      2'd0:    req_bad = 1'b0;
      2'd1:    req_bad = req_addr[0];
      2'd2:    req_bad = (req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // Store lane mask and replicated write data from the registered request.
  always_comb begin
    lane_mask  = 4'b1111;
    lane_wdata = wdata_q;
    unique case (size_q)
      2'd0: begin
        lane_mask  = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        lane_mask  = 4'b0011 << {addr_q[1], 1'b0};
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask  = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  // Load lane extraction with sign or zero extension.
  always_comb begin
    rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    rd_half  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    rd_ext   = mem_rdata;
    unique case (size_q)
      2'd0:    rd_ext = {{24{signed_q & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    rd_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  // Control FSM together with the request fields, response data and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wen_q    <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      fault_q  <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            wen_q    <= req_wen;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= 32'd0;
            cnt_q    <= 16'd0;
            fault_q  <= req_bad;
            state_q  <= req_bad ? StResp : StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= 16'd0;
          state_q <= wen_q ? StResp : StRdWait;
        end
        StRdWait: begin
          // Data arriving on the last allowed cycle still wins over the timeout.
          if (mem_rvalid) begin
            rdata_q <= rd_ext;
            fault_q <= 1'b0;
            state_q <= StResp;
          end else if (cnt_q == CntLast) begin
            rdata_q <= 32'd0;
            fault_q <= 1'b1;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StResp: begin
          if (resp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decoded from registered state; req_ready is masked while reset is held.
  always_comb begin
    req_ready  = rst_n && (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_rdata = rdata_q;
    resp_fault = fault_q && (state_q == StResp);
    mem_req    = (state_q == StIssue);
    mem_wen    = (state_q == StIssue) && wen_q;
    mem_wmask  = ((state_q == StIssue) && wen_q) ? lane_mask : 4'b0000;
    mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    mem_wdata  = lane_wdata;
  end

endmodule

// File: tb/tb_lsu_param.sv
// Self-checking bench for lsu_param: vector table with a scoreboard queue, plus
// hand-written sequences for response back-pressure and mid-operation reset.
module tb_lsu_param;

  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wen;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_fault;
  logic          mem_req;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  lsu_param #(.ADDR_W(AW), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_req    (mem_req),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // delay: RD_WAIT cycles before mem_rvalid (99 = never); lat: cycles from accept to resp_valid
  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          delay;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_mreq;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mwdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    vec_t e;
    int   issue_k;
    int   nreq;
    bit   done;
    v = vecs[idx];
    @(negedge clk);
    chk($sformatf("v%0d req_ready idle", idx), {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_wen    = v.wen;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    mem_rdata  = v.mrdata;
    sb.push_back(v);
    @(negedge clk);
    req_valid = 1'b0;
    issue_k = -1;
    nreq    = 0;
    done    = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      if (mem_req) begin
        nreq++;
        issue_k = k;
        chk($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_maddr);
        chk($sformatf("v%0d mem_wen", idx), {31'd0, mem_wen}, {31'd0, v.wen});
        if (v.wen) begin
          chk($sformatf("v%0d mem_wmask", idx), {28'd0, mem_wmask}, {28'd0, v.exp_mask});
          chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_mwdata);
        end
      end else begin
        chk($sformatf("v%0d idle wmask/wen k%0d", idx, k), {27'd0, mem_wen, mem_wmask}, 32'd0);
      end
      if (resp_valid) begin
        e = sb.pop_front();
        chk($sformatf("v%0d resp_rdata", idx), resp_rdata, e.exp_rdata);
        chk($sformatf("v%0d resp_fault", idx), {31'd0, resp_fault}, {31'd0, e.exp_fault});
        chk($sformatf("v%0d latency", idx), k, e.exp_lat);
        chk($sformatf("v%0d mem_req count", idx), nreq, e.exp_mreq);
        chk($sformatf("v%0d req_ready during resp", idx), {31'd0, req_ready}, 32'd0);
        done = 1'b1;
      end
      mem_rvalid = (issue_k > 0) && !done && (v.delay != 99) && (k == issue_k + 1 + v.delay);
      if (!done) @(negedge clk);
    end
    mem_rvalid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL v%0d response: got none expected resp_valid within 20 cycles", idx);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(negedge clk);
    chk($sformatf("v%0d req_ready after handshake", idx), {31'd0, req_ready}, 32'd1);
    chk($sformatf("v%0d resp_valid after handshake", idx), {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " req_ready"}, {31'd0, req_ready}, 32'd0);
    chk({name, " resp_valid/fault"}, {30'd0, resp_valid, resp_fault}, 32'd0);
    chk({name, " mem_req/wen/wmask"}, {26'd0, mem_req, mem_wen, mem_wmask}, 32'd0);
    chk({name, " resp_rdata"}, resp_rdata, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FF_FF7F, 0,
                 32'hFFFF_FF80, 1'b0, 1, 32'h1000, 4'b0000, 32'h0, 3};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_BEEF, 32'h0, 0,
                 32'h0, 1'b0, 1, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 2};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 0,
                 32'h0, 1'b1, 0, 32'h0, 4'b0000, 32'h0, 1};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'hAAAA_AAAA, 99,
                 32'h0, 1'b1, 1, 32'h4000, 4'b0000, 32'h0, 6};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h4004, 32'h0, 32'h1234_5678, 3,
                 32'h1234_5678, 1'b0, 1, 32'h4004, 4'b0000, 32'h0, 6};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h5001, 32'h0, 32'h0000_A500, 0,
                 32'h0000_00A5, 1'b0, 1, 32'h5000, 4'b0000, 32'h0, 3};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h6002, 32'h0, 32'h8001_1234, 0,
                 32'hFFFF_8001, 1'b0, 1, 32'h6000, 4'b0000, 32'h0, 3};
    vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h6002, 32'h0, 32'h8001_1234, 1,
                 32'h0000_8001, 1'b0, 1, 32'h6000, 4'b0000, 32'h0, 4};
    vecs[8]  = '{1'b1, 2'd0, 1'b0, 32'h7003, 32'h0000_005A, 32'h0, 0,
                 32'h0, 1'b0, 1, 32'h7000, 4'b1000, 32'h5A5A_5A5A, 2};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h8000, 32'hCAFE_F00D, 32'h0, 0,
                 32'h0, 1'b0, 1, 32'h8000, 4'b1111, 32'hCAFE_F00D, 2};
    vecs[10] = '{1'b1, 2'd3, 1'b0, 32'h9000, 32'h0000_0001, 32'h0, 0,
                 32'h0, 1'b1, 0, 32'h0, 4'b0000, 32'h0, 1};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h9001, 32'h0000_1234, 32'h0, 0,
                 32'h0, 1'b1, 0, 32'h0, 4'b0000, 32'h0, 1};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 32'h1000, 32'h0, 32'h0000_007F, 0,
                 32'h0000_007F, 1'b0, 1, 32'h1000, 4'b0000, 32'h0, 3};
    vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h7001, 32'hFFFF_FF33, 32'h0, 0,
                 32'h0, 1'b0, 1, 32'h7000, 4'b0010, 32'h3333_3333, 2};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;

    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    chk_all_zero("reset held");
    rst_n = 1'b1;
    #1;
    chk("req_ready after release", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 14; i++) run_vec(i);

    // Back-pressure: response held, late mem_rvalid pulse must be ignored.
    begin
      int  w;
      bit  seen;
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_wen    = 1'b0;
      req_size   = 2'd2;
      req_signed = 1'b0;
      req_addr   = 32'h0100;
      mem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      req_valid = 1'b0;
      seen = 1'b0;
      for (w = 0; w < 10 && !seen; w++) begin
        if (mem_req) seen = 1'b1;
        else @(negedge clk);
      end
      chk("bp mem_req seen", {31'd0, seen}, 32'd1);
      @(negedge clk);
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("bp resp_valid", {31'd0, resp_valid}, 32'd1);
      for (int c = 0; c < 5; c++) begin
        chk($sformatf("bp hold%0d resp_valid", c), {31'd0, resp_valid}, 32'd1);
        chk($sformatf("bp hold%0d resp_rdata", c), resp_rdata, 32'hDEAD_BEEF);
        chk($sformatf("bp hold%0d req_ready", c), {31'd0, req_ready}, 32'd0);
        chk($sformatf("bp hold%0d mem_req", c), {31'd0, mem_req}, 32'd0);
        mem_rvalid = (c == 1);
        mem_rdata  = (c == 1) ? 32'h1111_1111 : 32'hDEAD_BEEF;
        @(negedge clk);
      end
      mem_rvalid = 1'b0;
      chk("bp resp_fault", {31'd0, resp_fault}, 32'd0);
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp resp_valid cleared", {31'd0, resp_valid}, 32'd0);
      chk("bp req_ready back", {31'd0, req_ready}, 32'd1);
    end

    // Reset pulled during RD_WAIT aborts the load with no response.
    begin
      bit seen;
      @(negedge clk);
      req_valid  = 1'b1;
      req_wen    = 1'b0;
      req_size   = 2'd2;
      req_addr   = 32'h0200;
      mem_rdata  = 32'h5555_AAAA;
      @(negedge clk);
      req_valid = 1'b0;
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
        if (mem_req) seen = 1'b1;
        else @(negedge clk);
      end
      chk("rst mem_req seen", {31'd0, seen}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst mid RD_WAIT");
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk_all_zero("rst held");
      rst_n = 1'b1;
      #1;
      chk("rst release req_ready", {31'd0, req_ready}, 32'd1);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (resp_valid || mem_req) seen = 1'b1;
      end
      chk("rst no late resp/mem_req", {31'd0, seen}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion by 200000");
    $fatal(1);
  end

endmodule
